// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the instruction-memory read port, the fetch->datapath handshake and
// the redirect inputs of the fetch unit.
//   imem_req/imem_addr/imem_ready  : in-order read request channel
//   imem_rvalid/imem_rdata         : read response (in order, no backpressure)
//   instr_valid/instruction/instr_pc/instr_ready : word presented to datapath
//   redir_pc/branch_taken/branch_imm/jump/jump_target : redirect request
// master = fetch unit side, slave = memory/datapath side.
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [31:0] redir_pc;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_target;

    modport master (
        output imem_req, imem_addr, instr_valid, instruction, instr_pc,
        input  imem_ready, imem_rvalid, imem_rdata, instr_ready,
               redir_pc, branch_taken, branch_imm, jump, jump_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instruction, instr_pc,
        output imem_ready, imem_rvalid, imem_rdata, instr_ready,
               redir_pc, branch_taken, branch_imm, jump, jump_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage feeding a single-cycle MIPS datapath. Owns the PC, issues
// in-order reads to instruction memory, buffers returned words in a small
// FIFO and presents {instruction, pc} with a valid/ready handshake. Branch
// and jump redirects flush wrong-path words and restart fetch at the target.
// Ports:
//   clock   : single rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : instr_fetch_unit_if.master (memory, datapath, redirect signals)
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic          r_active;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr, r_wr_ptr;
    logic [PW-1:0] r_aq_rd, r_aq_wr;
    logic [31:0]   r_fifo_instr [FIFO_DEPTH];
    logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]   r_aq_pc      [FIFO_DEPTH];

    logic          w_redirect;
    logic [31:0]   w_base;
    logic [31:0]   w_br_off;
    logic [31:0]   w_target;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_req;
    logic          w_issue;
    logic [CW:0]   w_used;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Redirect target; jump wins when both are asserted.
    assign w_redirect = bus.jump || bus.branch_taken;
    assign w_base     = bus.redir_pc + 32'd4;
    assign w_br_off   = {{14{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};
    assign w_target   = bus.jump ? {w_base[31:28], bus.jump_target, 2'b00}
                                 : w_base + w_br_off;

    assign w_pop  = (r_count != '0) && bus.instr_ready;
    assign w_drop = bus.imem_rvalid && (r_drop_cnt != '0);
    assign w_push = bus.imem_rvalid && !w_drop && !w_redirect;

    // Credit counts a same-cycle pop as a freed slot so a one-cycle memory
    // sustains one word per cycle with a two-entry buffer.
    assign w_used  = {1'b0, r_outstanding} + {1'b0, r_count} - (CW+1)'(w_pop);
    assign w_req   = r_active && !w_redirect && (w_used < (CW+1)'(FIFO_DEPTH));
    assign w_issue = w_req && bus.imem_ready;

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.instr_valid = (r_count != '0);
    assign bus.instruction = r_fifo_instr[r_rd_ptr];
    assign bus.instr_pc    = r_fifo_pc[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_active      <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_aq_rd       <= '0;
            r_aq_wr       <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
                r_aq_pc[i]      <= '0;
            end
        end else begin
            r_active <= 1'b1;

            if (w_issue && !bus.imem_rvalid)
                r_outstanding <= r_outstanding + CW'(1);
            else if (!w_issue && bus.imem_rvalid)
                r_outstanding <= r_outstanding - CW'(1);

            // Address queue tracks every outstanding request, dropped or not,
            // so it always pairs each response with its issue address.
            if (w_issue) begin
                r_aq_pc[r_aq_wr] <= r_fetch_pc;
                r_aq_wr          <= f_inc(r_aq_wr);
                r_fetch_pc       <= r_fetch_pc + 32'd4;
            end
            if (bus.imem_rvalid)
                r_aq_rd <= f_inc(r_aq_rd);

            if (w_redirect) begin
                // Every response still pending after this edge is wrong-path.
                r_fetch_pc <= w_target;
                r_drop_cnt <= r_outstanding - CW'(bus.imem_rvalid);
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_drop)
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                if (w_push) begin
                    r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
                    r_fifo_pc[r_wr_ptr]    <= r_aq_pc[r_aq_rd];
                    r_wr_ptr               <= f_inc(r_wr_ptr);
                end
                if (w_pop)
                    r_rd_ptr <= f_inc(r_rd_ptr);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: ;
                endcase
            end
        end
    end
endmodule
